// File: rtl/tx_frame_controller.sv
// tx_frame_controller: read-side sequencer for the transmitter input FIFO.
// Pops PAYLOAD_LEN bytes per frame and emits SYNC_BYTE, payload, checksum
// to the serializer over a valid/ready handshake (read_clk domain).
// Optional macro TX_CRC8_EN: checksum byte becomes CRC-8 (poly 0x07, init 0,
// MSB-first, no reflection, no final XOR) instead of the 8-bit modular sum.
module tx_frame_controller #(
  parameter int unsigned PAYLOAD_LEN = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic        read_clk,
  input  logic        arst,
  input  logic        enable,
  input  logic        input_ready,
  input  logic [7:0]  fifo_data,
  output logic        read_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {IDLE, SYNC, REQ, WAIT, SEND, CSUM} state_t;

  state_t      state, state_nxt;
  logic [7:0]  csum, csum_nxt;
  logic [7:0]  count, count_nxt;
  logic [3:0]  holdoff, holdoff_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, sof_nxt, eof_nxt;
  logic [15:0] fc_nxt;
  logic        xfer;

  // Fold one payload byte into the running checksum.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] d);
`ifdef TX_CRC8_EN
    logic [7:0] c;
    c = acc ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc + d;
`endif
  endfunction

  assign xfer     = tx_valid & tx_ready;
  assign read_req = (state == REQ);
  assign busy     = (state != IDLE);

  // Next-state and next-value logic for the sequencer and its output registers.
  always_comb begin
    state_nxt   = state;
    data_nxt    = tx_data;
    valid_nxt   = tx_valid;
    sof_nxt     = tx_sof;
    eof_nxt     = tx_eof;
    csum_nxt    = csum;
    count_nxt   = count;
    holdoff_nxt = holdoff;
    fc_nxt      = frame_count;
    case (state)
      IDLE: begin
        if (holdoff == '0 && enable && input_ready) begin
          state_nxt = SYNC;
          data_nxt  = SYNC_BYTE;
          valid_nxt = 1'b1;
          sof_nxt   = 1'b1;
          csum_nxt  = '0;
          count_nxt = '0;
        end else if (holdoff != '0) begin
          holdoff_nxt = holdoff - 4'd1;
        end
      end
      SYNC: begin
        if (xfer) begin
          state_nxt = REQ;
          valid_nxt = 1'b0;
          sof_nxt   = 1'b0;
        end
      end
      REQ: state_nxt = WAIT;
      WAIT: begin
        state_nxt = SEND;
        data_nxt  = fifo_data;
        valid_nxt = 1'b1;
        csum_nxt  = csum_update(csum, fifo_data);
      end
      SEND: begin
        if (xfer) begin
          if (count == 8'(PAYLOAD_LEN - 1)) begin
            state_nxt = CSUM;
            data_nxt  = csum;
            valid_nxt = 1'b1;
            eof_nxt   = 1'b1;
          end else begin
            state_nxt = REQ;
            count_nxt = count + 8'd1;
            valid_nxt = 1'b0;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b0;
          eof_nxt     = 1'b0;
          fc_nxt      = frame_count + 16'd1;
          holdoff_nxt = 4'(HOLDOFF);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge read_clk or negedge arst) begin
    if (!arst) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_sof      <= 1'b0;
      tx_eof      <= 1'b0;
      csum        <= '0;
      count       <= '0;
      holdoff     <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      tx_data     <= data_nxt;
      tx_valid    <= valid_nxt;
      tx_sof      <= sof_nxt;
      tx_eof      <= eof_nxt;
      csum        <= csum_nxt;
      count       <= count_nxt;
      holdoff     <= holdoff_nxt;
      frame_count <= fc_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_controller.sv
// Directed testbench for tx_frame_controller.
module tb_tx_frame_controller;

`ifdef TX_CRC8_EN
  localparam int unsigned PL       = 9;
  localparam logic [7:0]  BASE     = 8'h31;   // ASCII "123456789"
  localparam logic [7:0]  EXP_CSUM = 8'hF4;   // CRC-8/0x07 check value
`else
  localparam int unsigned PL       = 10;
  localparam logic [7:0]  BASE     = 8'h01;   // payload 01..0A
  localparam logic [7:0]  EXP_CSUM = 8'h37;   // 1+2+...+10 = 55
`endif
  localparam int unsigned HO = 2;

  logic        read_clk = 1'b0;
  logic        arst = 1'b1;
  logic        enable = 1'b0;
  logic        input_ready = 1'b0;
  logic [7:0]  fifo_data;
  logic        read_req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_sof;
  logic        tx_eof;
  logic        busy;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  tx_frame_controller #(
    .PAYLOAD_LEN (PL),
    .SYNC_BYTE   (8'hA5),
    .HOLDOFF     (HO)
  ) dut (
    .read_clk    (read_clk),
    .arst        (arst),
    .enable      (enable),
    .input_ready (input_ready),
    .fifo_data   (fifo_data),
    .read_req    (read_req),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 read_clk = ~read_clk;

  // FIFO model: returns BASE+pos the cycle after each pop, payload-aligned.
  int fifo_pos;
  always @(posedge read_clk or negedge arst) begin
    if (!arst) begin
      fifo_pos  <= 0;
      fifo_data <= 8'h00;
    end else if (read_req) begin
      fifo_data <= BASE + 8'(fifo_pos);
      fifo_pos  <= (fifo_pos == PL - 1) ? 0 : fifo_pos + 1;
    end
  end

  // Serializer model: ready always, or one cycle in three when stalling.
  logic stall_mode = 1'b0;
  int   phase = 0;
  always @(posedge read_clk) begin
    #1;
    if (stall_mode) begin
      tx_ready = (phase == 0);
      phase    = (phase + 1) % 3;
    end else begin
      tx_ready = 1'b1;
      phase    = 0;
    end
  end

  // Monitor: logs accepted bytes and tracks protocol counters.
  logic [7:0] log_data [0:511];
  logic       log_sof  [0:511];
  logic       log_eof  [0:511];
  int log_n = 0, rr_cnt = 0, rr_bad = 0, stall_bad = 0, sof_cnt = 0;
  int busy_run = 0, gap_run = 0, last_busy = 0, last_gap = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] p_data;
  logic       p_sof, p_eof;
  always @(negedge read_clk) begin
    if (!arst) begin
      prev_stall <= 1'b0;
    end else begin
      if (tx_valid && tx_ready && log_n < 512) begin
        log_data[log_n] <= tx_data;
        log_sof[log_n]  <= tx_sof;
        log_eof[log_n]  <= tx_eof;
        log_n           <= log_n + 1;
        if (tx_sof) sof_cnt <= sof_cnt + 1;
      end
      if (read_req) rr_cnt <= rr_cnt + 1;
      if (read_req && tx_valid) rr_bad <= rr_bad + 1;
      if (prev_stall && (!tx_valid || tx_data !== p_data || tx_sof !== p_sof || tx_eof !== p_eof))
        stall_bad <= stall_bad + 1;
      prev_stall <= tx_valid && !tx_ready;
      p_data     <= tx_data;
      p_sof      <= tx_sof;
      p_eof      <= tx_eof;
    end
    if (busy) begin
      busy_run <= busy_run + 1;
      if (gap_run > 0) begin last_gap <= gap_run; gap_run <= 0; end
    end else begin
      gap_run <= gap_run + 1;
      if (busy_run > 0) begin last_busy <= busy_run; busy_run <= 0; end
    end
  end

  function automatic logic [7:0] exp_byte(input int i);
    if (i == 0) return 8'hA5;
    if (i == PL + 1) return EXP_CSUM;
    return BASE + 8'(i - 1);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(negedge read_clk); #1; end
  endtask

  task automatic wait_fc(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (frame_count !== target && n < budget) begin tick(1); n++; end
    if (frame_count !== target) begin
      checks++; errors++;
      $display("FAIL %s_timeout frame_count=%h required %h", tag, frame_count, target);
    end
  endtask

  task automatic test_reset;
    arst = 1'b1;
    #2 arst = 1'b0;
    #1;
    checks++;
    if ({read_req, tx_valid, tx_sof, tx_eof, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000", {read_req, tx_valid, tx_sof, tx_eof, busy});
    end
    checks++;
    if (tx_data !== 8'h00 || frame_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got tx_data=%h frame_count=%h required 00/0000", tx_data, frame_count);
    end
    tick(3);
    arst = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_frame;
    int b = log_n;
    int r0 = rr_cnt;
    enable = 1'b1;
    input_ready = 1'b1;
    wait_fc(16'd1, 200, "basic");
    input_ready = 1'b0;
    tick(2);
    for (int i = 0; i < PL + 2; i++) begin
      checks++;
      if (log_data[b+i] !== exp_byte(i) || log_sof[b+i] !== (i == 0) || log_eof[b+i] !== (i == PL + 1)) begin
        errors++;
        $display("FAIL basic_byte[%0d] got %h sof=%b eof=%b required %h", i, log_data[b+i], log_sof[b+i], log_eof[b+i], exp_byte(i));
      end
    end
    checks++;
    if (log_n - b !== PL + 2) begin
      errors++; $display("FAIL basic_len got %0d required %0d", log_n - b, PL + 2);
    end
    checks++;
    if (rr_cnt - r0 !== PL) begin
      errors++; $display("FAIL basic_read_req got %0d required %0d", rr_cnt - r0, PL);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++; $display("FAIL basic_frame_count got %0d required 1", frame_count);
    end
    checks++;
    if (last_busy !== 2 + 3 * PL) begin
      errors++; $display("FAIL basic_frame_cycles got %0d required %0d", last_busy, 2 + 3 * PL);
    end
  endtask

  task automatic test_stall;
    int b = log_n;
    int r0 = rr_cnt;
    int s0 = stall_bad;
    int v0 = rr_bad;
    logic [15:0] fc0 = frame_count;
    tick(4);
    stall_mode = 1'b1;
    input_ready = 1'b1;
    wait_fc(fc0 + 16'd1, 600, "stall");
    input_ready = 1'b0;
    stall_mode = 1'b0;
    tick(4);
    for (int i = 0; i < PL + 2; i++) begin
      checks++;
      if (log_data[b+i] !== exp_byte(i) || log_sof[b+i] !== (i == 0) || log_eof[b+i] !== (i == PL + 1)) begin
        errors++;
        $display("FAIL stall_byte[%0d] got %h sof=%b eof=%b required %h", i, log_data[b+i], log_sof[b+i], log_eof[b+i], exp_byte(i));
      end
    end
    checks++;
    if (stall_bad - s0 !== 0) begin
      errors++; $display("FAIL stall_hold got %0d unstable stalls required 0", stall_bad - s0);
    end
    checks++;
    if (rr_bad - v0 !== 0) begin
      errors++; $display("FAIL stall_req_while_valid got %0d required 0", rr_bad - v0);
    end
    checks++;
    if (rr_cnt - r0 !== PL) begin
      errors++; $display("FAIL stall_read_req got %0d required %0d", rr_cnt - r0, PL);
    end
  endtask

  task automatic test_back_to_back;
    int b = log_n;
    int sc0 = sof_cnt;
    int n = 0;
    logic [15:0] fc0 = frame_count;
    tick(5);
    input_ready = 1'b1;
    wait_fc(fc0 + 16'd1, 200, "b2b_first");
    while (!busy && n < 20) begin tick(1); n++; end
    enable = 1'b0;
    wait_fc(fc0 + 16'd2, 200, "b2b_second");
    tick(3 * PL + 20);
    checks++;
    if (frame_count !== fc0 + 16'd2) begin
      errors++; $display("FAIL b2b_frame_count got %0d required %0d", frame_count, fc0 + 16'd2);
    end
    checks++;
    if (sof_cnt - sc0 !== 2) begin
      errors++; $display("FAIL b2b_frames_started got %0d required 2", sof_cnt - sc0);
    end
    // Idle span = HOLDOFF countdown cycles plus the IDLE cycle that starts the frame.
    checks++;
    if (last_gap !== HO + 1) begin
      errors++; $display("FAIL b2b_gap got %0d required %0d", last_gap, HO + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_busy got %b required 0", busy);
    end
    for (int i = 0; i < PL + 2; i++) begin
      checks++;
      if (log_data[b+PL+2+i] !== exp_byte(i) || log_sof[b+PL+2+i] !== (i == 0) || log_eof[b+PL+2+i] !== (i == PL + 1)) begin
        errors++;
        $display("FAIL b2b_byte[%0d] got %h required %h", i, log_data[b+PL+2+i], exp_byte(i));
      end
    end
    input_ready = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_async_reset;
    int b = log_n;
    int n = 0;
    tick(5);
    arst = 1'b0;
    tick(1);
    arst = 1'b1;
    tick(1);
    input_ready = 1'b1;
    while (!((log_n - b) == 6 && tx_valid) && n < 200) begin tick(1); n++; end
    arst = 1'b0;
    #1;
    checks++;
    if ({read_req, tx_valid, tx_sof, tx_eof, busy} !== 5'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL arst_outputs got flags=%b tx_data=%h required 00000/00", {read_req, tx_valid, tx_sof, tx_eof, busy}, tx_data);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++; $display("FAIL arst_frame_count got %0d required 0", frame_count);
    end
    @(negedge read_clk); #1;
    arst = 1'b1;
    b = log_n;
    wait_fc(16'd1, 200, "arst_restart");
    input_ready = 1'b0;
    tick(2);
    for (int i = 0; i < PL + 2; i++) begin
      checks++;
      if (log_data[b+i] !== exp_byte(i) || log_sof[b+i] !== (i == 0) || log_eof[b+i] !== (i == PL + 1)) begin
        errors++;
        $display("FAIL arst_byte[%0d] got %h sof=%b required %h", i, log_data[b+i], log_sof[b+i], exp_byte(i));
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++; $display("FAIL arst_restart_count got %0d required 1", frame_count);
    end
  endtask

  task automatic test_wrap;
    tick(6);
    force dut.frame_count = 16'hFFFF;
    tick(1);
    release dut.frame_count;
    input_ready = 1'b1;
    wait_fc(16'h0000, 200, "wrap");
    input_ready = 1'b0;
    tick(2);
    checks++;
    if (frame_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_count got %h required 0000", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
